// File: rtl/rv_skid_pipe.sv
// -----------------------------------------------------------------------------
// rv_skid_pipe
//
// Purpose:
//   Valid/ready register pipeline built from STAGES cascaded stages. Each
//   stage is either a two-entry skid buffer whose upstream ready is a flop
//   (SKID=1, no combinational out_ready -> in_ready path), or a one-entry
//   register slice whose upstream ready is combinational (SKID=0). Beats
//   leave in arrival order. A synchronous flush drops every held beat, and
//   the block keeps a registered count of the beats it currently holds.
//
// Parameters:
//   DATA_W  payload width in bits (1..512)
//   STAGES  number of cascaded stages (1..8)
//   SKID    1 = two-entry skid stage, 0 = one-entry slice
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous drop of all held beats
//   in_valid   in   upstream beat present
//   in_ready   out  block accepts the upstream beat
//   in_data    in   upstream payload
//   out_valid  out  downstream beat present
//   out_ready  in   downstream accepts the beat
//   out_data   out  downstream payload
//   occupancy  out  number of beats held (pushes minus pops)
// -----------------------------------------------------------------------------
module rv_skid_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1,
  parameter int SKID   = 1,
  localparam int CAP   = STAGES * ((SKID != 0) ? 2 : 1),
  localparam int OCC_W = $clog2(CAP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1'b1);

  // Inter-stage handshake links. Index k is the upstream side of stage k;
  // index STAGES is the downstream side of the whole pipe.
  logic              w_v [0:STAGES];
  logic [DATA_W-1:0] w_d [0:STAGES];
  logic              w_r [0:STAGES];

  logic              w_accept_ok;
  logic              w_push_in;
  logic              w_pop_out;
  logic [OCC_W-1:0]  r_occ;

  // Nothing is accepted during reset or flush; the gate sits on both the
  // ready we advertise and the valid we hand to the first stage so that the
  // first stage never sees a push the upstream did not see as a transfer.
  assign w_accept_ok = ~rst & ~flush;
  assign in_ready    = w_r[0] & w_accept_ok;
  assign w_v[0]      = in_valid & w_accept_ok;
  assign w_d[0]      = in_data;
  assign w_r[STAGES] = out_ready;
  assign out_valid   = w_v[STAGES] & ~rst;
  assign out_data    = w_d[STAGES];
  assign occupancy   = r_occ;

  assign w_push_in = in_valid & in_ready;
  assign w_pop_out = out_valid & out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (SKID != 0) begin : g_skid
      skid_state_e       r_state;
      skid_state_e       w_state_nxt;
      logic              r_rdy;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic              w_push;
      logic              w_pop;
      logic              w_ld_main_in;
      logic              w_ld_main_skid;
      logic              w_ld_skid;

      assign w_push = w_v[k] & r_rdy;
      assign w_pop  = (r_state != ST_EMPTY) & w_r[k+1];

      // State register; ready is re-registered from the next state so the
      // upstream ready is a pure flop output.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= ST_EMPTY;
          r_rdy   <= 1'b1;
        end else if (flush) begin
          r_state <= ST_EMPTY;
          r_rdy   <= 1'b1;
        end else begin
          r_state <= w_state_nxt;
          r_rdy   <= (w_state_nxt != ST_FULL);
        end
      end

      // Next-state decode for the EMPTY / ONE / FULL occupancy of this stage.
      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          ST_EMPTY: begin
            if (w_push) begin
              w_state_nxt = ST_ONE;
            end else begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_ONE: begin
            if (w_push && !w_pop) begin
              w_state_nxt = ST_FULL;
            end else if (!w_push && w_pop) begin
              w_state_nxt = ST_EMPTY;
            end else begin
              w_state_nxt = ST_ONE;
            end
          end
          ST_FULL: begin
            if (w_pop) begin
              w_state_nxt = ST_ONE;
            end else begin
              w_state_nxt = ST_FULL;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end

      // Output decode: which payload register loads from where this cycle.
      // In FULL no push can occur because r_rdy is low.
      always_comb begin
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
          ST_EMPTY: begin
            w_ld_main_in = w_push;
          end
          ST_ONE: begin
            w_ld_main_in = w_push & w_pop;
            w_ld_skid    = w_push & ~w_pop;
          end
          ST_FULL: begin
            w_ld_main_skid = w_pop;
          end
          default: begin
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
          end
        endcase
      end

      // Payload registers: cleared by reset, frozen during flush, otherwise
      // loaded only on an accepted transfer.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_main <= '0;
          r_skid <= '0;
        end else if (!flush) begin
          if (w_ld_main_in) begin
            r_main <= w_d[k];
          end else if (w_ld_main_skid) begin
            r_main <= r_skid;
          end
          if (w_ld_skid) begin
            r_skid <= w_d[k];
          end
        end
      end

      assign w_r[k]   = r_rdy;
      assign w_v[k+1] = (r_state != ST_EMPTY);
      assign w_d[k+1] = r_main;
    end else begin : g_slice
      logic              r_vld;
      logic [DATA_W-1:0] r_data;
      logic              w_rdy;
      logic              w_push;

      // Ready passes straight through from downstream when the slot is held.
      assign w_rdy  = ~r_vld | w_r[k+1];
      assign w_push = w_v[k] & w_rdy;

      // Valid flag: set on push, cleared on a pop without a push.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= 1'b0;
        end else if (flush) begin
          r_vld <= 1'b0;
        end else if (w_push) begin
          r_vld <= 1'b1;
        end else if (w_r[k+1]) begin
          r_vld <= 1'b0;
        end
      end

      // Payload register: cleared by reset, loaded only on a push.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_push && !flush) begin
          r_data <= w_d[k];
        end
      end

      assign w_r[k]   = w_rdy;
      assign w_v[k+1] = r_vld;
      assign w_d[k+1] = r_data;
    end
  end

  // Held-beat counter; internal stage-to-stage moves do not change the total.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_push_in, w_pop_out})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_skid_pipe.sv
// -----------------------------------------------------------------------------
// tb_rv_skid_pipe
//
// Two instances share one upstream/downstream stimulus stream:
//   u_a : STAGES=2, SKID=1 (capacity 4)
//   u_b : STAGES=3, SKID=0 (capacity 3)
// Each instance has its own scoreboard queue: a beat is pushed when the bench
// sees in_valid & in_ready before an edge and popped/compared when it sees
// out_valid & out_ready. The expected occupancy is the queue depth.
// -----------------------------------------------------------------------------
module tb_rv_skid_pipe;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready;
  logic       a_out_valid;
  logic [7:0] a_out_data;
  logic [2:0] a_occ;

  logic       b_in_ready;
  logic       b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_occ;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  logic       a_hold   = 1'b0;
  logic [7:0] a_hold_d = 8'd0;
  logic       b_hold   = 1'b0;
  logic [7:0] b_hold_d = 8'd0;

  rv_skid_pipe #(.DATA_W(8), .STAGES(2), .SKID(1)) u_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ)
  );

  rv_skid_pipe #(.DATA_W(8), .STAGES(3), .SKID(0)) u_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were driven just after the previous falling edge.
  task automatic tick();
    logic [31:0] exp_v;
    #1;
    // instance A: stability, pop, push
    if (a_hold && !rst) begin
      chk("a_hold_valid", 32'(a_out_valid), 32'd1);
      chk("a_hold_data", 32'(a_out_data), 32'(a_hold_d));
    end
    if (rst || flush) chk("a_rdy_blocked", 32'(a_in_ready), 32'd0);
    if (rst) chk("a_ovalid_in_rst", 32'(a_out_valid), 32'd0);
    if (a_out_valid && out_ready) begin
      exp_v = (q_a.size() > 0) ? 32'(q_a.pop_front()) : 32'hDEAD_BEEF;
      chk("a_order", 32'(a_out_data), exp_v);
    end
    if (in_valid && a_in_ready) q_a.push_back(in_data);
    a_hold   = a_out_valid && !out_ready && !flush && !rst;
    a_hold_d = a_out_data;
    if (rst || flush) q_a.delete();
    // instance B
    if (b_hold && !rst) begin
      chk("b_hold_valid", 32'(b_out_valid), 32'd1);
      chk("b_hold_data", 32'(b_out_data), 32'(b_hold_d));
    end
    if (rst || flush) chk("b_rdy_blocked", 32'(b_in_ready), 32'd0);
    if (rst) chk("b_ovalid_in_rst", 32'(b_out_valid), 32'd0);
    if (b_out_valid && out_ready) begin
      exp_v = (q_b.size() > 0) ? 32'(q_b.pop_front()) : 32'hDEAD_BEEF;
      chk("b_order", 32'(b_out_data), exp_v);
    end
    if (in_valid && b_in_ready) q_b.push_back(in_data);
    b_hold   = b_out_valid && !out_ready && !flush && !rst;
    b_hold_d = b_out_data;
    if (rst || flush) q_b.delete();

    @(posedge clk);
    #1;
    chk("a_occ", 32'(a_occ), 32'(q_a.size()));
    chk("b_occ", 32'(b_occ), 32'(q_b.size()));
    chk("a_occ_cap", 32'(a_occ <= 3'd4), 32'd1);
    if (rst) begin
      chk("a_rst_ovalid", 32'(a_out_valid), 32'd0);
      chk("a_rst_odata", 32'(a_out_data), 32'd0);
      chk("b_rst_ovalid", 32'(b_out_valid), 32'd0);
      chk("b_rst_odata", 32'(b_out_data), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n, input bit allow_flush);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = allow_flush && ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    tick();
    tick();

    // first cycle after reset: ready in both modes
    rst = 1'b0;
    #1;
    chk("a_rdy_after_rst", 32'(a_in_ready), 32'd1);
    chk("b_rdy_after_rst", 32'(b_in_ready), 32'd1);

    // minimum latency: A shows the beat after 2 edges, B after 3
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    tick();
    chk("a_lat_e0", 32'(a_out_valid), 32'd0);
    chk("b_lat_e0", 32'(b_out_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("a_lat_e1", 32'(a_out_valid), 32'd1);
    chk("a_lat_data", 32'(a_out_data), 32'h11);
    chk("b_lat_e1", 32'(b_out_valid), 32'd0);
    tick();
    chk("b_lat_e2", 32'(b_out_valid), 32'd1);
    chk("b_lat_data", 32'(b_out_data), 32'h11);
    tick();

    // full-rate stream 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      #1;
      chk("a_stream_rdy", 32'(a_in_ready), 32'd1);
      chk("b_stream_rdy", 32'(b_in_ready), 32'd1);
      tick();
      if (i >= 2) chk("a_stream_valid", 32'(a_out_valid), 32'd1);
      if (i >= 3) chk("b_stream_valid", 32'(b_out_valid), 32'd1);
    end
    chk("a_stream_occ", 32'(a_occ), 32'd2);
    chk("b_stream_occ", 32'(b_occ), 32'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // backpressure: A takes 4 of 5 offered beats
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h20 + i);
      #1;
      chk("a_bp_rdy", 32'(a_in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("a_bp_occ", 32'(a_occ), 32'd4);
    chk("b_bp_occ", 32'(b_occ), 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("a_bp_rdy_back", 32'(a_in_ready), 32'd1);
    chk("a_bp_drained", 32'(a_occ), 32'd0);

    // flush with A holding 3 beats and 0xAA offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      tick();
    end
    chk("a_pre_flush_occ", 32'(a_occ), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick();
    chk("a_flush_occ", 32'(a_occ), 32'd0);
    chk("a_flush_ovalid", 32'(a_out_valid), 32'd0);
    chk("b_flush_occ", 32'(b_occ), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // random traffic with occasional flush
    rand_cycles(3000, 1'b1);

    // reset pulse mid-stream
    rand_cycles(100, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("a_rdy_post_rst", 32'(a_in_ready), 32'd1);
    chk("b_rdy_post_rst", 32'(b_in_ready), 32'd1);
    rand_cycles(300, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("a_final_empty", 32'(q_a.size()), 32'd0);
    chk("b_final_empty", 32'(q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
